// File: rtl/spi_slave_responder_if.sv
// rtl/spi_slave_responder_if.sv - Avalon-MM register port and interrupt of the SPI responder
`timescale 1ns/1ps
interface spi_slave_responder_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;

  modport master (
    output spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  data_to_cpu, irq
  );

  modport slave (
    input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output data_to_cpu, irq
  );
endinterface

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 responder endpoint with Avalon-MM registers and irq
`timescale 1ns/1ps
module spi_slave_responder #(
  parameter int                  DATABITS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [DATABITS-1:0] FILL_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_slave_responder_if.slave bus,
  input  logic                 SCLK,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_oe
);
  localparam int              BC_W      = $clog2(DATABITS + 1);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(DATABITS - 1);
  localparam logic [BC_W-1:0] BC_FULL   = BC_W'(DATABITS);
  localparam logic [7:0]      CTRL_MASK = 8'hFA;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAIT_FALL} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic rd_req, wr_req, rd_req_d, wr_req_d, rd_strobe, wr_strobe;
  logic rx_read, tx_write, stat_write, ctrl_write, fill_write;
  logic tx_accept, load_take;

  logic do_load, do_sample, do_shift, do_byte, do_abort;

  logic [DATABITS-1:0] shift_reg, rx_holding, tx_holding, fill;
  logic [BC_W-1:0]     bitcount;
  logic                sample;
  logic                tx_primed;
  logic                rrdy, tur, roe, abt, toe, ssa;
  logic [7:0]          control, status;
  logic [15:0]         rd_mux;
  logic                unused_wdata;

  // Oversample the asynchronous pins; an extra delay flop on SCLK/SS_n feeds the edge detectors.
  // Everything clears to 0 so a frame already in progress at reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  // Bus strobes fire on the first cycle of an access and re-arm once the request drops
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req_d <= 1'b0;
      wr_req_d <= 1'b0;
    end else begin
      rd_req_d <= rd_req;
      wr_req_d <= wr_req;
    end
  end

  assign rd_req     = bus.spi_select & ~bus.read_n;
  assign wr_req     = bus.spi_select & ~bus.write_n;
  assign rd_strobe  = rd_req & ~rd_req_d;
  assign wr_strobe  = wr_req & ~wr_req_d;
  assign rx_read    = rd_strobe & (bus.mem_addr == 3'd0);
  assign tx_write   = wr_strobe & (bus.mem_addr == 3'd1);
  assign stat_write = wr_strobe & (bus.mem_addr == 3'd2);
  assign ctrl_write = wr_strobe & (bus.mem_addr == 3'd3);
  assign fill_write = wr_strobe & (bus.mem_addr == 3'd4);

  // A LOAD that consumes the holding register frees it for a write landing in the same cycle
  assign load_take  = do_load & tx_primed;
  assign tx_accept  = tx_write & (~tx_primed | load_take);

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Frame sequencing: SS deassertion overrides everything, SCLK edges only matter inside a frame
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    do_byte    = 1'b0;
    do_abort   = 1'b0;
    if (ss_rise) begin
      state_next = IDLE;
      do_abort   = (bitcount != '0);
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) state_next = LOAD;
        end
        LOAD: begin
          do_load    = 1'b1;
          state_next = SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            do_sample = 1'b1;
            if (bitcount == BC_LAST) begin
              do_byte    = 1'b1;
              state_next = WAIT_FALL;
            end
          end else if (sclk_fall && (bitcount < BC_FULL)) begin
            do_shift = 1'b1;
          end
        end
        WAIT_FALL: begin
          if (sclk_fall) state_next = LOAD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Shift datapath: MOSI is captured on the rise and enters the register on the following fall
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= '0;
      rx_holding <= '0;
      bitcount   <= '0;
      sample     <= 1'b0;
    end else begin
      if (do_load) shift_reg <= tx_primed ? tx_holding : fill;
      else if (do_shift) shift_reg <= {shift_reg[DATABITS-2:0], sample};
      if (do_sample) sample <= mosi_s;
      if (do_abort) bitcount <= '0;
      else if (do_byte) bitcount <= '0;
      else if (do_sample) bitcount <= bitcount + BC_W'(1);
      if (do_byte) rx_holding <= {shift_reg[DATABITS-2:0], mosi_s};
    end
  end

  // Sticky status flags (set beats clear), transmit holding register and host configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      rrdy       <= 1'b0;
      tur        <= 1'b0;
      roe        <= 1'b0;
      abt        <= 1'b0;
      toe        <= 1'b0;
      tx_primed  <= 1'b0;
      tx_holding <= '0;
      control    <= '0;
      fill       <= FILL_RESET;
    end else begin
      if (do_byte) rrdy <= 1'b1;
      else if (rx_read || stat_write) rrdy <= 1'b0;
      if (do_byte && rrdy && !rx_read) roe <= 1'b1;
      else if (stat_write) roe <= 1'b0;
      if (do_load && !tx_primed) tur <= 1'b1;
      else if (stat_write) tur <= 1'b0;
      if (do_abort) abt <= 1'b1;
      else if (stat_write) abt <= 1'b0;
      if (tx_write && !tx_accept) toe <= 1'b1;
      else if (stat_write) toe <= 1'b0;
      if (tx_accept) begin
        tx_holding <= bus.data_from_cpu[DATABITS-1:0];
        tx_primed  <= 1'b1;
      end else if (load_take) begin
        tx_primed <= 1'b0;
      end
      if (ctrl_write) control <= bus.data_from_cpu[7:0] & CTRL_MASK;
      if (fill_write) fill <= bus.data_from_cpu[DATABITS-1:0];
    end
  end

  assign ssa     = (state != IDLE);
  assign status  = {rrdy, ~tx_primed, tur, roe, abt, ssa, toe, 1'b0};
  assign MISO    = ssa & shift_reg[DATABITS-1];
  assign MISO_oe = ssa;

  assign unused_wdata = ^bus.data_from_cpu;

  // Register read mux
  always_comb begin
    rd_mux = '0;
    case (bus.mem_addr)
      3'd0:    rd_mux = 16'(rx_holding);
      3'd2:    rd_mux = {8'h00, status};
      3'd3:    rd_mux = {8'h00, control};
      3'd4:    rd_mux = 16'(fill);
      default: rd_mux = '0;
    endcase
  end

  // Registered read data and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_to_cpu <= '0;
      bus.irq         <= 1'b0;
    end else begin
      bus.data_to_cpu <= rd_mux;
      bus.irq         <= |(status & control);
    end
  end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - self-checking bench for spi_slave_responder
`timescale 1ns/1ps
module tb_spi_slave_responder;
  localparam int         HALF      = 6;
  localparam logic [7:0] FILL_INIT = 8'hE7;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic SCLK, SS_n, MOSI, MISO, MISO_oe;
  int   tests = 0;
  int   fails = 0;

  spi_slave_responder_if bus ();

  spi_slave_responder #(
    .DATABITS(8), .SYNC_STAGES(2), .FILL_RESET(FILL_INIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Behavioural reference: register-level view of the responder
  logic       m_rrdy, m_tur, m_roe, m_abt, m_toe, m_primed;
  logic [7:0] m_hold, m_fill, m_ctrl, m_rx;
  logic [7:0] mo_q[$];

  task automatic m_reset();
    m_rrdy = 0; m_tur = 0; m_roe = 0; m_abt = 0; m_toe = 0; m_primed = 0;
    m_hold = 0; m_fill = FILL_INIT; m_ctrl = 0; m_rx = 0;
  endtask

  function automatic logic [15:0] m_status();
    return {8'h00, m_rrdy, ~m_primed, m_tur, m_roe, m_abt, 1'b0, m_toe, 1'b0};
  endfunction

  function automatic logic m_irq();
    logic [15:0] s;
    s = m_status();
    return |(s[7:0] & m_ctrl);
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {8'h00, m_rx};
      3'd2:    return m_status();
      3'd3:    return {8'h00, m_ctrl};
      3'd4:    return {8'h00, m_fill};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_load(output logic [7:0] b);
    if (m_primed) begin
      b = m_hold;
      m_primed = 0;
    end else begin
      b = m_fill;
      m_tur = 1;
    end
  endtask

  task automatic m_rx_byte(input logic [7:0] b);
    if (m_rrdy) m_roe = 1;
    m_rrdy = 1;
    m_rx = b;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.spi_select = 1; bus.write_n = 0; bus.mem_addr = a; bus.data_from_cpu = d;
    @(negedge clk);
    bus.spi_select = 0; bus.write_n = 1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.spi_select = 1; bus.read_n = 0; bus.mem_addr = a;
    @(negedge clk);
    d = bus.data_to_cpu;
    bus.spi_select = 0; bus.read_n = 1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    bus_wr(a, d);
    case (a)
      3'd1: if (!m_primed) begin m_hold = d[7:0]; m_primed = 1; end else m_toe = 1;
      3'd2: begin m_rrdy = 0; m_tur = 0; m_roe = 0; m_abt = 0; m_toe = 0; end
      3'd3: m_ctrl = d[7:0] & 8'hFA;
      3'd4: m_fill = d[7:0];
      default: ;
    endcase
  endtask

  task automatic do_read_check(input logic [2:0] a, input string name, output logic [15:0] rd);
    logic [15:0] exp;
    exp = m_read(a);
    bus_rd(a, rd);
    check(name, rd, exp);
    if (a == 3'd0) m_rrdy = 0;
  endtask

  task automatic check_irq(input string name);
    tick(2);
    check(name, bus.irq, m_irq());
  endtask

  // SPI master, mode 0, MSB first: MISO is sampled just before each rising edge
  task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = mo[7-i];
      tick(HALF);
      mi[7-i] = MISO;
      SCLK = 1;
      tick(HALF);
      SCLK = 0;
    end
    tick(HALF);
  endtask

  // n full bytes, then either a k-bit partial byte (abort) or a clean end
  task automatic frame(input int n, input int k, input string tag);
    logic [7:0] b, mo, mi, mask;
    SS_n = 0;
    tick(3);
    check({tag, " oe on"}, MISO_oe, 1'b1);
    for (int i = 0; i < n; i++) begin
      mo = (mo_q.size() != 0) ? mo_q.pop_front() : 8'($urandom);
      m_load(b);
      spi_bits(8, mo, mi);
      check($sformatf("%s miso byte%0d", tag, i), mi, b);
      m_rx_byte(mo);
    end
    m_load(b);
    if (k > 0) begin
      mo = 8'($urandom);
      spi_bits(k, mo, mi);
      mask = 8'hFF << (8 - k);
      check({tag, " miso partial"}, mi, b & mask);
      m_abt = 1;
    end
    SS_n = 1;
    tick(HALF);
    check({tag, " oe off"}, MISO_oe, 1'b0);
  endtask

  initial begin
    vec_t        vecs[12];
    logic [15:0] rd;
    logic [7:0]  mi, b;
    int          op;

    vecs[0]  = '{wr: 1'b0, addr: 3'd2, data: 16'h0000, exp: 16'h0040};
    vecs[1]  = '{wr: 1'b0, addr: 3'd3, data: 16'h0000, exp: 16'h0000};
    vecs[2]  = '{wr: 1'b0, addr: 3'd4, data: 16'h0000, exp: 16'h00E7};
    vecs[3]  = '{wr: 1'b0, addr: 3'd0, data: 16'h0000, exp: 16'h0000};
    vecs[4]  = '{wr: 1'b0, addr: 3'd5, data: 16'h0000, exp: 16'h0000};
    vecs[5]  = '{wr: 1'b1, addr: 3'd3, data: 16'hFFFF, exp: 16'h0000};
    vecs[6]  = '{wr: 1'b0, addr: 3'd3, data: 16'h0000, exp: 16'h00FA};
    vecs[7]  = '{wr: 1'b1, addr: 3'd4, data: 16'hAB12, exp: 16'h0000};
    vecs[8]  = '{wr: 1'b0, addr: 3'd4, data: 16'h0000, exp: 16'h0012};
    vecs[9]  = '{wr: 1'b1, addr: 3'd3, data: 16'h0000, exp: 16'h0000};
    vecs[10] = '{wr: 1'b0, addr: 3'd7, data: 16'h0000, exp: 16'h0000};
    vecs[11] = '{wr: 1'b0, addr: 3'd6, data: 16'h0000, exp: 16'h0000};

    bus.spi_select = 0; bus.read_n = 1; bus.write_n = 1;
    bus.mem_addr = 0; bus.data_from_cpu = 0;
    SCLK = 0; SS_n = 1; MOSI = 0; reset = 1;
    m_reset();
    tick(3);
    check("reset data_to_cpu", bus.data_to_cpu, 16'h0000);
    check("reset irq", bus.irq, 1'b0);
    check("reset MISO", MISO, 1'b0);
    check("reset MISO_oe", MISO_oe, 1'b0);
    reset = 0;
    tick(3);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_rd(vecs[i].addr, rd);
        check($sformatf("vec%0d addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
        if (vecs[i].addr == 3'd0) m_rrdy = 0;
      end
    end

    // Primed single byte
    do_write(3'd1, 16'h00A5);
    mo_q.push_back(8'h3C);
    frame(1, 0, "t1");
    do_read_check(3'd2, "t1 status before read", rd);
    do_read_check(3'd0, "t1 rxdata", rd);
    check("t1 rxdata const", rd, 16'h003C);
    do_read_check(3'd2, "t1 status after read", rd);
    check("t1 rrdy cleared", rd[7], 1'b0);

    // Three-byte burst, single txdata write, fill fallback
    do_write(3'd2, 16'h0000);
    do_write(3'd4, 16'h0055);
    do_write(3'd1, 16'h0081);
    mo_q.push_back(8'h11); mo_q.push_back(8'h22); mo_q.push_back(8'h33);
    frame(3, 0, "t2");
    do_read_check(3'd2, "t2 status", rd);
    check("t2 tur roe", rd & 16'h0030, 16'h0030);
    do_read_check(3'd0, "t2 rxdata last", rd);

    // Abort after five rises, then a clean frame
    do_write(3'd2, 16'h0000);
    frame(0, 5, "t3 abort");
    do_read_check(3'd2, "t3 status abt", rd);
    check("t3 abt rrdy", rd & 16'h0088, 16'h0008);
    mo_q.push_back(8'h96);
    frame(1, 0, "t3 next");
    do_read_check(3'd0, "t3 rxdata", rd);

    // Double txdata write overflows, first value kept
    do_write(3'd2, 16'h0000);
    do_write(3'd1, 16'h0011);
    do_write(3'd1, 16'h0022);
    do_read_check(3'd2, "t4 status toe", rd);
    frame(1, 0, "t4");

    // Receive interrupt
    do_write(3'd2, 16'h0000);
    do_write(3'd3, 16'h0080);
    check_irq("t5 irq idle");
    frame(1, 0, "t5");
    check_irq("t5 irq set");
    do_read_check(3'd0, "t5 rxdata", rd);
    check_irq("t5 irq cleared");
    do_write(3'd2, 16'h0000);
    do_read_check(3'd2, "t5 status cleared", rd);
    do_write(3'd3, 16'h0000);

    // Randomised operations against the model
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: do_write(3'd1, 16'($urandom));
        1: do_write(3'd4, 16'($urandom));
        2: do_read_check(3'd0, $sformatf("rnd%0d rxdata", it), rd);
        3: do_read_check(3'd2, $sformatf("rnd%0d status", it), rd);
        4: frame($urandom_range(1, 3), 0, $sformatf("rnd%0d frame", it));
        5: frame($urandom_range(0, 1), $urandom_range(1, 7), $sformatf("rnd%0d abort", it));
        6: do_write(3'd2, 16'h0000);
        default: do_write(3'd3, 16'($urandom));
      endcase
      check_irq($sformatf("rnd%0d irq", it));
    end

    // Reset in the middle of a byte
    do_write(3'd2, 16'h0000);
    do_write(3'd4, 16'h00FF);
    do_write(3'd3, 16'h0020);
    bus_rd(3'd2, rd);
    SS_n = 0;
    tick(3);
    m_load(b);
    spi_bits(4, 8'hA0, mi);
    check("rst pre MISO_oe", MISO_oe, 1'b1);
    check("rst pre MISO", MISO, b[3]);
    check("rst pre data_to_cpu", bus.data_to_cpu, m_status() | 16'h0004);
    check("rst pre irq", bus.irq, m_irq());
    reset = 1;
    tick(1);
    check("rst data_to_cpu", bus.data_to_cpu, 16'h0000);
    check("rst irq", bus.irq, 1'b0);
    check("rst MISO", MISO, 1'b0);
    check("rst MISO_oe", MISO_oe, 1'b0);
    reset = 0;
    SCLK = 0;
    m_reset();
    tick(2);
    SS_n = 1;
    tick(HALF);
    do_write(3'd1, 16'h005A);
    mo_q.push_back(8'hC3);
    frame(1, 0, "post rst");
    do_read_check(3'd2, "post rst status", rd);
    do_read_check(3'd0, "post rst rxdata", rd);
    check("post rst rxdata const", rd, 16'h00C3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
